xswitch_egress_buffer: RTL and testbench
========================================

Name: xswitch_egress_buffer

Overview:
- Per-output-port receiver that sits directly downstream of the xswitch crossbar; one instance is placed per switch output.
- Consumes the switch's valid_out/data_out/addr_out for its port and acknowledges each captured word with data_rd.
- Advertises free space to the switch on rcv_rdy, checks the destination address, and buffers good words in a first-word-fall-through FIFO for the bench monitor or the next block.

Parameters:
- DATA_W, 8, data word width.
- ADDR_W, 8, address field width.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- PORT_ID, 0, expected addr_out value for this port.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- valid_out  input  1  switch presents a word for this port.
- data_out  input  DATA_W  word from the switch.
- addr_out  input  ADDR_W  destination address from the switch.
- rcv_rdy  output  1  receiver can accept a word this cycle.
- data_rd  output  1  one-cycle acknowledge of a captured word.
- pkt_valid  output  1  FIFO head is valid.
- pkt_data  output  DATA_W  FIFO head data.
- pkt_addr  output  ADDR_W  FIFO head address.
- pkt_ready  input  1  downstream consumes the head this cycle.
- flush  input  1  synchronous FIFO clear.
- count  output  log2(DEPTH)+1  current occupancy.
- misroute_cnt  output  8  saturating count of dropped misaddressed words.

Behaviour:
- Reset (reset=1 at a clk edge): FIFO empty, count=0, rcv_rdy=0, data_rd=0, pkt_valid=0, pkt_data=0, pkt_addr=0, misroute_cnt=0. On the first cycle after reset deasserts, rcv_rdy=1.
- Reset applied mid-operation discards all stored words and any pending acknowledge; data_rd is never issued for a word that was accepted in the cycle reset is high.
- Accept: accept = valid_out && rcv_rdy, sampled at the clk edge.
  - valid_out while rcv_rdy=0 is ignored; the switch holds the word. This is not an error.
- data_rd is registered: it goes high exactly one cycle after the accept edge, for one cycle per accepted word.
  - Back-to-back accepts give data_rd high on consecutive cycles.
- Address check on accept:
  - addr_out == PORT_ID: push {addr_out, data_out}.
  - Otherwise: no push; misroute_cnt increments (saturating at 255); data_rd still pulses.
- Pop: pop = pkt_valid && pkt_ready.
  - pkt_data/pkt_addr show the head entry combinationally from storage.
  - pkt_valid = (count != 0).
  - Popped data is not required to be cleared.
- count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged; head and tail pointers each advance.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- rcv_rdy is registered: rcv_rdy <= (count_next < DEPTH) && !flush.
  - A push can therefore never occur when the FIFO is full, so overflow is impossible by construction.
  - With DEPTH=4: after the 4th push, rcv_rdy is 0 in the next cycle.
  - A pop in the same cycle as the 4th push keeps rcv_rdy=1.
- Underflow: pop while empty cannot occur because pkt_valid=0; pkt_ready is ignored when empty.
- Control FSM, states RUN and FLUSH:
  - RUN -> FLUSH when flush=1. In the FLUSH cycle, pointers and count are cleared, rcv_rdy=0, and the accept at that edge is ignored (no data_rd, no push).
  - FLUSH -> RUN when flush=0. rcv_rdy returns to 1 one cycle later.
  - A data_rd already scheduled from an accept before flush still pulses.
  - misroute_cnt is not cleared by flush.
- Priority: reset > flush > push/pop.
- No combinational path from valid_out to rcv_rdy, or from pkt_ready to rcv_rdy.

Test Plan:
- Reset then single word, PORT_ID=3: reset 2 cycles; valid_out=1, addr_out=3, data_out=8'hA5 for one accepted cycle -> data_rd high exactly one cycle later; pkt_valid=1, pkt_data=A5, pkt_addr=3; count=1.
- Fill to full, DEPTH=4, pkt_ready=0: push 11,22,33,44 on consecutive cycles -> rcv_rdy=0 the cycle after the 4th accept; a 5th word 55 held on valid_out gets no data_rd; count=4. Then pkt_ready=1 for one cycle -> 11 popped, rcv_rdy=1 next cycle, 55 accepted; read order 22,33,44,55.
- Simultaneous push/pop at count=2 -> count stays 2, order preserved. Run 10 words through to exercise pointer wrap -> output order matches input order.
- Misroute, PORT_ID=3: send addr_out=5, data 8'h77 -> data_rd pulses, count unchanged, misroute_cnt=1. Send 260 misroutes -> misroute_cnt=255.
- Flush with count=3 while valid_out=1 -> count=0, pkt_valid=0, no data_rd for the flush-cycle word, rcv_rdy=0 during flush and 1 one cycle after flush drops. A later word is read correctly.
- Reset mid-stream with count=2 and an accept on the reset edge -> all outputs at reset values, no data_rd the following cycle.

Source files
------------

// File: rtl/xswitch_egress_buffer.sv
// Per-output-port egress receiver for the xswitch crossbar: acknowledges switch words,
// drops misaddressed ones, and buffers the rest in a first-word-fall-through FIFO.
module xswitch_egress_buffer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PORT_ID = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_out,
    input  logic [DATA_W-1:0]        data_out,
    input  logic [ADDR_W-1:0]        addr_out,
    output logic                     rcv_rdy,
    output logic                     data_rd,
    output logic                     pkt_valid,
    output logic [DATA_W-1:0]        pkt_data,
    output logic [ADDR_W-1:0]        pkt_addr,
    input  logic                     pkt_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               misroute_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic                clear_c;
    logic                accept_c;
    logic                push_c;
    logic                pop_c;

    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                rcv_rdy_q, rcv_rdy_d;
    logic                data_rd_q, data_rd_d;
    logic [7:0]          misroute_q, misroute_d;
    logic [DATA_W-1:0]   data_mem_q [DEPTH];
    logic [DATA_W-1:0]   data_mem_d [DEPTH];
    logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
    logic [ADDR_W-1:0]   addr_mem_d [DEPTH];

    // Control FSM: any cycle with flush high clears the FIFO and blocks accepts
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    clear_c = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush) begin
                    clear_c = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Datapath next-state: accept/ack, address filter, FIFO pointers and occupancy
    always_comb begin
        accept_c   = valid_out && rcv_rdy_q && !clear_c;
        push_c     = accept_c && (addr_out == ADDR_W'(PORT_ID));
        pop_c      = (count_q != '0) && pkt_ready && !clear_c;

        data_mem_d = data_mem_q;
        addr_mem_d = addr_mem_q;
        misroute_d = misroute_q;

        if (clear_c) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        end

        if (push_c) begin
            data_mem_d[wr_ptr_q] = data_out;
            addr_mem_d[wr_ptr_q] = addr_out;
        end

        if (accept_c && !push_c && (misroute_q != 8'hFF)) begin
            misroute_d = misroute_q + 8'd1;
        end

        data_rd_d = accept_c;
        // Registered from next occupancy so a full FIFO is never offered a word
        rcv_rdy_d = (count_d < CNT_W'(DEPTH)) && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rcv_rdy_q  <= 1'b0;
            data_rd_q  <= 1'b0;
            misroute_q <= '0;
            data_mem_q <= '{default: '0};
            addr_mem_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rcv_rdy_q  <= rcv_rdy_d;
            data_rd_q  <= data_rd_d;
            misroute_q <= misroute_d;
            data_mem_q <= data_mem_d;
            addr_mem_q <= addr_mem_d;
        end
    end

    assign rcv_rdy      = rcv_rdy_q;
    assign data_rd      = data_rd_q;
    assign pkt_valid    = (count_q != '0);
    assign pkt_data     = data_mem_q[rd_ptr_q];
    assign pkt_addr     = addr_mem_q[rd_ptr_q];
    assign count        = count_q;
    assign misroute_cnt = misroute_q;

endmodule

// File: tb/tb_xswitch_egress_buffer.sv
// Self-checking bench for xswitch_egress_buffer (PORT_ID=3, DEPTH=4) against a queue-based model.
module tb_xswitch_egress_buffer;

    logic       clk;
    logic       reset;
    logic       valid_out;
    logic [7:0] data_out;
    logic [7:0] addr_out;
    logic       rcv_rdy;
    logic       data_rd;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic [7:0] pkt_addr;
    logic       pkt_ready;
    logic       flush;
    logic [2:0] count;
    logic [7:0] misroute_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_q[$];
    logic        m_rdy;
    logic        m_drd;
    int          m_mis;

    xswitch_egress_buffer #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(4), .PORT_ID(3)
    ) dut (
        .clk(clk), .reset(reset), .valid_out(valid_out), .data_out(data_out),
        .addr_out(addr_out), .rcv_rdy(rcv_rdy), .data_rd(data_rd),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_addr(pkt_addr),
        .pkt_ready(pkt_ready), .flush(flush), .count(count),
        .misroute_cnt(misroute_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance model by one edge using current inputs, then step the clock
    task automatic cycle();
        logic acc, push, pop;
        acc = valid_out && m_rdy;
        if (reset) begin
            m_q.delete(); m_rdy = 1'b0; m_drd = 1'b0; m_mis = 0;
        end else if (flush) begin
            m_q.delete(); m_rdy = 1'b0; m_drd = 1'b0;
        end else begin
            pop  = (m_q.size() != 0) && pkt_ready;
            push = acc && (addr_out == 8'd3);
            m_drd = acc;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({addr_out, data_out});
            if (acc && !push && m_mis < 255) m_mis++;
            m_rdy = (m_q.size() < 4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_out = 0; pkt_ready = 0; flush = 0;
        reset = 1; cycle(); cycle();
        reset = 0; cycle();
    endtask

    task automatic push_word(input logic [7:0] d);
        valid_out = 1; addr_out = 8'd3; data_out = d;
        cycle();
        valid_out = 0;
    endtask

    task automatic test_reset();
        valid_out = 0; pkt_ready = 0; flush = 0; data_out = 0; addr_out = 0;
        reset = 1; cycle(); cycle();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (rcv_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rcv_rdy got %b exp 0", rcv_rdy); end
        n_cmp++; if (data_rd !== 1'b0) begin n_err++; $display("FAIL reset_data_rd got %b exp 0", data_rd); end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL reset_pkt_valid got %b exp 0", pkt_valid); end
        n_cmp++; if ({pkt_data, pkt_addr} !== 16'h0) begin n_err++; $display("FAIL reset_pkt got %h/%h exp 0/0", pkt_data, pkt_addr); end
        n_cmp++; if (misroute_cnt !== 8'd0) begin n_err++; $display("FAIL reset_misroute got %0d exp 0", misroute_cnt); end
        reset = 0; cycle();
        n_cmp++; if (rcv_rdy !== 1'b1) begin n_err++; $display("FAIL post_reset_rcv_rdy got %b exp 1", rcv_rdy); end
    endtask

    task automatic test_single();
        push_word(8'hA5);
        n_cmp++; if (data_rd !== 1'b1) begin n_err++; $display("FAIL single_data_rd got %b exp 1", data_rd); end
        n_cmp++; if (pkt_valid !== 1'b1 || pkt_data !== 8'hA5 || pkt_addr !== 8'd3) begin
            n_err++; $display("FAIL single_head got v=%b %h/%h exp v=1 a5/03", pkt_valid, pkt_data, pkt_addr); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d exp 1", count); end
        cycle();
        n_cmp++; if (data_rd !== 1'b0) begin n_err++; $display("FAIL single_data_rd_drop got %b exp 0", data_rd); end
        pkt_ready = 1; cycle(); pkt_ready = 0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_drain got %0d exp 0", count); end
    endtask

    task automatic test_fill();
        logic [7:0] words [4];
        logic [7:0] exp_rd [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_rd = '{8'h22, 8'h33, 8'h44, 8'h55};
        for (int k = 0; k < 4; k++) begin
            push_word(words[k]);
            n_cmp++; if (data_rd !== 1'b1) begin n_err++; $display("FAIL fill_data_rd[%0d] got %b exp 1", k, data_rd); end
        end
        n_cmp++; if (rcv_rdy !== 1'b0 || count !== 3'd4) begin
            n_err++; $display("FAIL fill_full got rdy=%b cnt=%0d exp rdy=0 cnt=4", rcv_rdy, count); end
        valid_out = 1; data_out = 8'h55; addr_out = 8'd3;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_cmp++; if (data_rd !== 1'b0 || count !== 3'd4) begin
                n_err++; $display("FAIL fill_hold[%0d] got drd=%b cnt=%0d exp drd=0 cnt=4", k, data_rd, count); end
        end
        n_cmp++; if (pkt_data !== 8'h11) begin n_err++; $display("FAIL fill_head got %h exp 11", pkt_data); end
        pkt_ready = 1; cycle(); pkt_ready = 0;
        n_cmp++; if (rcv_rdy !== 1'b1 || count !== 3'd3) begin
            n_err++; $display("FAIL fill_pop got rdy=%b cnt=%0d exp rdy=1 cnt=3", rcv_rdy, count); end
        cycle();
        valid_out = 0;
        n_cmp++; if (data_rd !== 1'b1 || count !== 3'd4) begin
            n_err++; $display("FAIL fill_accept55 got drd=%b cnt=%0d exp drd=1 cnt=4", data_rd, count); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (pkt_data !== exp_rd[k]) begin n_err++; $display("FAIL fill_order[%0d] got %h exp %h", k, pkt_data, exp_rd[k]); end
            pkt_ready = 1; cycle();
        end
        pkt_ready = 0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL fill_drain got %0d exp 0", count); end
    endtask

    task automatic test_simul();
        push_word(8'hC1); push_word(8'hC2);
        valid_out = 1; data_out = 8'hC3; addr_out = 8'd3; pkt_ready = 1;
        n_cmp++; if (pkt_data !== 8'hC1) begin n_err++; $display("FAIL simul_head got %h exp c1", pkt_data); end
        cycle();
        valid_out = 0; pkt_ready = 0;
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL simul_count got %0d exp 2", count); end
        n_cmp++; if (pkt_data !== 8'hC2) begin n_err++; $display("FAIL simul_order0 got %h exp c2", pkt_data); end
        pkt_ready = 1; cycle();
        n_cmp++; if (pkt_data !== 8'hC3) begin n_err++; $display("FAIL simul_order1 got %h exp c3", pkt_data); end
        cycle(); pkt_ready = 0;
    endtask

    task automatic test_wrap();
        logic [7:0] sent [10];
        logic [7:0] got [$];
        int idx = 0;
        for (int k = 0; k < 10; k++) sent[k] = 8'($urandom_range(0, 255));
        pkt_ready = 1; addr_out = 8'd3;
        for (int cyc = 0; cyc < 60 && got.size() < 10; cyc++) begin
            logic acc;
            valid_out = (idx < 10);
            data_out = (idx < 10) ? sent[idx] : 8'h00;
            acc = valid_out && m_rdy;
            if (pkt_valid && pkt_ready) got.push_back(pkt_data);
            cycle();
            if (acc) idx++;
        end
        valid_out = 0; pkt_ready = 0;
        n_cmp++; if (got.size() != 10) begin n_err++; $display("FAIL wrap_count got %0d exp 10", got.size()); end
        for (int k = 0; k < 10 && k < got.size(); k++) begin
            n_cmp++; if (got[k] !== sent[k]) begin n_err++; $display("FAIL wrap_order[%0d] got %h exp %h", k, got[k], sent[k]); end
        end
    endtask

    task automatic test_misroute();
        do_reset();
        valid_out = 1; addr_out = 8'd5; data_out = 8'h77;
        cycle();
        valid_out = 0;
        n_cmp++; if (data_rd !== 1'b1 || count !== 3'd0 || misroute_cnt !== 8'd1) begin
            n_err++; $display("FAIL misroute_one got drd=%b cnt=%0d mis=%0d exp 1/0/1", data_rd, count, misroute_cnt); end
        valid_out = 1;
        for (int k = 0; k < 260; k++) cycle();
        valid_out = 0;
        n_cmp++; if (misroute_cnt !== 8'd255) begin n_err++; $display("FAIL misroute_sat got %0d exp 255", misroute_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        push_word(8'h01); push_word(8'h02); push_word(8'h03);
        valid_out = 1; addr_out = 8'd3; data_out = 8'h99; flush = 1;
        cycle();
        n_cmp++; if (count !== 3'd0 || pkt_valid !== 1'b0 || data_rd !== 1'b0 || rcv_rdy !== 1'b0) begin
            n_err++; $display("FAIL flush_clear got cnt=%0d v=%b drd=%b rdy=%b exp 0/0/0/0", count, pkt_valid, data_rd, rcv_rdy); end
        flush = 0; data_out = 8'h5A;
        cycle();
        n_cmp++; if (rcv_rdy !== 1'b1 || data_rd !== 1'b0 || count !== 3'd0) begin
            n_err++; $display("FAIL flush_exit got rdy=%b drd=%b cnt=%0d exp 1/0/0", rcv_rdy, data_rd, count); end
        cycle();
        valid_out = 0;
        n_cmp++; if (data_rd !== 1'b1 || pkt_data !== 8'h5A || count !== 3'd1) begin
            n_err++; $display("FAIL flush_after got drd=%b d=%h cnt=%0d exp 1/5a/1", data_rd, pkt_data, count); end
        n_cmp++; if (misroute_cnt !== 8'(m_mis)) begin n_err++; $display("FAIL flush_mis got %0d exp %0d", misroute_cnt, m_mis); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_word(8'hE1); push_word(8'hE2);
        valid_out = 1; addr_out = 8'd3; data_out = 8'hE3; reset = 1;
        cycle();
        n_cmp++; if (count !== 3'd0 || rcv_rdy !== 1'b0 || data_rd !== 1'b0 || pkt_valid !== 1'b0
                     || pkt_data !== 8'h0 || pkt_addr !== 8'h0 || misroute_cnt !== 8'h0) begin
            n_err++; $display("FAIL rstmid_outputs got cnt=%0d rdy=%b drd=%b v=%b d=%h a=%h mis=%0d exp all 0",
                              count, rcv_rdy, data_rd, pkt_valid, pkt_data, pkt_addr, misroute_cnt); end
        reset = 0; valid_out = 0;
        cycle();
        n_cmp++; if (data_rd !== 1'b0 || rcv_rdy !== 1'b1 || count !== 3'd0) begin
            n_err++; $display("FAIL rstmid_after got drd=%b rdy=%b cnt=%0d exp 0/1/0", data_rd, rcv_rdy, count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            valid_out = ($urandom_range(0, 9) < 7);
            addr_out  = ($urandom_range(0, 4) == 0) ? 8'd5 : 8'd3;
            data_out  = 8'($urandom_range(0, 255));
            pkt_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 39) == 0);
            cycle();
            n_cmp++; if (data_rd !== m_drd || rcv_rdy !== m_rdy) begin
                n_err++; $display("FAIL rand_hs[%0d] got drd=%b rdy=%b exp drd=%b rdy=%b", cyc, data_rd, rcv_rdy, m_drd, m_rdy); end
            n_cmp++; if (count !== 3'(m_q.size()) || pkt_valid !== (m_q.size() != 0)) begin
                n_err++; $display("FAIL rand_count[%0d] got cnt=%0d v=%b exp %0d", cyc, count, pkt_valid, m_q.size()); end
            n_cmp++; if (misroute_cnt !== 8'(m_mis)) begin
                n_err++; $display("FAIL rand_mis[%0d] got %0d exp %0d", cyc, misroute_cnt, m_mis); end
            if (m_q.size() != 0) begin
                n_cmp++; if ({pkt_addr, pkt_data} !== m_q[0]) begin
                    n_err++; $display("FAIL rand_head[%0d] got %h%h exp %h", cyc, pkt_addr, pkt_data, m_q[0]); end
            end
        end
        valid_out = 0; pkt_ready = 0; flush = 0;
    endtask

    initial begin
        reset = 1; valid_out = 0; data_out = 0; addr_out = 0; pkt_ready = 0; flush = 0;
        m_rdy = 0; m_drd = 0; m_mis = 0;
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_wrap();
        test_misroute();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
